// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the RV32I multicycle controller
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } statetype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic logic [2:0] immsrc_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: immsrc_of = IMM_I;
      OP_SW:       immsrc_of = IMM_S;
      OP_BEQ:      immsrc_of = IMM_B;
      OP_JAL:      immsrc_of = IMM_J;
      OP_LUI:      immsrc_of = IMM_U;
      default:     immsrc_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp and instruction function bits to ALUControl
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for R-type; for addi it is an immediate bit
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle RV32I datapath
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite
);

  statetype   state, nextstate, ostate;
  logic [1:0] ALUOp;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextstate;
  end

  always_comb begin
    nextstate = FETCH;
    case (state)
      FETCH:    nextstate = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_R:         nextstate = EXECUTER;
          OP_I:         nextstate = EXECUTEI;
          OP_BEQ:       nextstate = BEQ;
          OP_JAL:       nextstate = JAL;
          OP_LUI:       nextstate = LUI;
          default:      nextstate = FETCH;
        endcase
      end
      MEMADR:   nextstate = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  nextstate = MemReady ? MEMWB : MEMREAD;
      MEMWB:    nextstate = FETCH;
      MEMWRITE: nextstate = MemReady ? FETCH : MEMWRITE;
      EXECUTER: nextstate = ALUWB;
      EXECUTEI: nextstate = ALUWB;
      LUI:      nextstate = ALUWB;
      ALUWB:    nextstate = FETCH;
      BEQ:      nextstate = FETCH;
      JAL:      nextstate = ALUWB;
      default:  nextstate = FETCH;
    endcase
  end

  // During reset the datapath selects look like FETCH and every strobe is held low.
  assign ostate = reset ? FETCH : state;

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    case (ostate)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_READDATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      ALUWB:    RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        PCWrite = Zero;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign ImmSrc = immsrc_of(op);

  alu_decoder u_alu_decoder (
    .ALUOp      (ALUOp),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed vector bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'h40008093;
  localparam logic [31:0] I_ORI  = 32'h00006093;
  localparam logic [31:0] I_AND  = 32'h000070B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_LW   = 32'h00402283;
  localparam logic [31:0] I_SW   = 32'h00502423;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_LUI  = 32'h12345337;
  localparam logic [31:0] I_ILL  = 32'h0000000F;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        mr;
    logic        z;
    logic        rst;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nchecks = 0;
  int   nfail = 0;

  function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] res,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic [2:0] aluc,
                                     input logic rw);
    return {pcw, adr, mw, irw, res, sa, sb, imm, aluc, rw};
  endfunction

  function automatic logic [16:0] xf(input logic mr, input logic [2:0] imm);
    return ev(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
  endfunction

  function automatic logic [16:0] xd(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
  endfunction

  function automatic logic [16:0] xwb(input logic [2:0] imm);
    return ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
  endfunction

  task automatic add(input string n, input logic [31:0] i, input logic mr, input logic z,
                     input logic rst, input logic [16:0] e);
    vec_t v;
    v.name = n; v.instr = i; v.mr = mr; v.z = z; v.rst = rst; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [31:0] i, input logic mr, input logic z, input logic rst);
    @(negedge clk);
    op = i[6:0]; funct3 = i[14:12]; funct7b5 = i[30];
    MemReady = mr; Zero = z; reset = rst;
    #1;
  endtask

  task automatic apply(input vec_t v);
    logic [16:0] got;
    drive(v.instr, v.mr, v.z, v.rst);
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite};
    nchecks++;
    if (got !== v.exp) begin
      nfail++;
      $display("FAIL %s: got %b required %b", v.name, got, v.exp);
    end
  endtask

  task automatic check(input string n, input int got, input int req);
    nchecks++;
    if (got != req) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d", n, got, req);
    end
  endtask

  initial begin
    vec_t v;
    int   cyc_end, rw_cnt, rw_rd_cnt, imm_bad;

    add("rst0", I_ADD, 1, 0, 1, ev(0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
    add("rst1", I_ADD, 1, 0, 1, ev(0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
    add("add.F", I_ADD, 1, 0, 0, xf(1, 3'b000));
    add("add.D", I_ADD, 0, 0, 0, xd(3'b000));
    add("add.X", I_ADD, 0, 0, 0, ev(0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b000,0));
    add("add.WB", I_ADD, 1, 0, 0, xwb(3'b000));
    add("sub.F", I_SUB, 1, 0, 0, xf(1, 3'b000));
    add("sub.D", I_SUB, 1, 0, 0, xd(3'b000));
    add("sub.X", I_SUB, 1, 0, 0, ev(0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001,0));
    add("sub.WB", I_SUB, 1, 0, 0, xwb(3'b000));
    add("addi.F", I_ADDI, 1, 0, 0, xf(1, 3'b000));
    add("addi.D", I_ADDI, 1, 0, 0, xd(3'b000));
    add("addi.X", I_ADDI, 1, 0, 0, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
    add("addi.WB", I_ADDI, 1, 0, 0, xwb(3'b000));
    add("ori.F", I_ORI, 1, 0, 0, xf(1, 3'b000));
    add("ori.D", I_ORI, 1, 0, 0, xd(3'b000));
    add("ori.X", I_ORI, 1, 0, 0, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b011,0));
    add("ori.WB", I_ORI, 1, 0, 0, xwb(3'b000));
    add("and.F", I_AND, 1, 0, 0, xf(1, 3'b000));
    add("and.D", I_AND, 1, 0, 0, xd(3'b000));
    add("and.X", I_AND, 1, 0, 0, ev(0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b010,0));
    add("and.WB", I_AND, 1, 0, 0, xwb(3'b000));
    add("slt.F", I_SLT, 1, 0, 0, xf(1, 3'b000));
    add("slt.D", I_SLT, 1, 0, 0, xd(3'b000));
    add("slt.X", I_SLT, 1, 0, 0, ev(0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b101,0));
    add("slt.WB", I_SLT, 1, 0, 0, xwb(3'b000));
    add("sw.F", I_SW, 1, 0, 0, xf(1, 3'b001));
    add("sw.D", I_SW, 0, 0, 0, xd(3'b001));
    add("sw.MA", I_SW, 0, 0, 0, ev(0,0,0,0,2'b00,2'b10,2'b01,3'b001,3'b000,0));
    add("sw.MW0", I_SW, 0, 0, 0, ev(0,1,1,0,2'b00,2'b00,2'b00,3'b001,3'b000,0));
    add("sw.MW1", I_SW, 1, 0, 0, ev(0,1,1,0,2'b00,2'b00,2'b00,3'b001,3'b000,0));
    add("beqT.F", I_BEQ, 1, 1, 0, xf(1, 3'b010));
    add("beqT.D", I_BEQ, 1, 1, 0, xd(3'b010));
    add("beqT.B", I_BEQ, 1, 1, 0, ev(1,0,0,0,2'b00,2'b10,2'b00,3'b010,3'b001,0));
    add("beqN.F", I_BEQ, 1, 0, 0, xf(1, 3'b010));
    add("beqN.D", I_BEQ, 1, 0, 0, xd(3'b010));
    add("beqN.B", I_BEQ, 1, 0, 0, ev(0,0,0,0,2'b00,2'b10,2'b00,3'b010,3'b001,0));
    add("jal.F", I_JAL, 1, 0, 0, xf(1, 3'b011));
    add("jal.D", I_JAL, 1, 0, 0, xd(3'b011));
    add("jal.J", I_JAL, 1, 0, 0, ev(1,0,0,0,2'b00,2'b01,2'b10,3'b011,3'b000,0));
    add("jal.WB", I_JAL, 1, 0, 0, xwb(3'b011));
    add("lui.F", I_LUI, 1, 0, 0, xf(1, 3'b100));
    add("lui.D", I_LUI, 1, 0, 0, xd(3'b100));
    add("lui.L", I_LUI, 1, 0, 0, ev(0,0,0,0,2'b00,2'b11,2'b01,3'b100,3'b000,0));
    add("lui.WB", I_LUI, 1, 0, 0, xwb(3'b100));
    add("ill.Fstall", I_ILL, 0, 0, 0, xf(0, 3'b000));
    add("ill.F", I_ILL, 1, 0, 0, xf(1, 3'b000));
    add("ill.D", I_ILL, 1, 0, 0, xd(3'b000));
    add("ill.back", I_ILL, 0, 0, 0, xf(0, 3'b000));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

    // lw with two stall cycles in MEMREAD; the next fetch should appear on cycle 8
    cyc_end = 0; rw_cnt = 0; rw_rd_cnt = 0; imm_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      drive(I_LW, !(c == 4 || c == 5), 0, 0);
      if (ImmSrc !== 3'b000) imm_bad++;
      if (c > 1 && IRWrite === 1'b1) begin
        cyc_end = c;
        break;
      end
      if (RegWrite === 1'b1) begin
        rw_cnt++;
        if (ResultSrc === 2'b01) rw_rd_cnt++;
      end
    end
    check("lw.next_fetch_cycle", cyc_end, 8);
    check("lw.regwrite_count", rw_cnt, 1);
    check("lw.regwrite_readdata", rw_rd_cnt, 1);
    check("lw.immsrc_errors", imm_bad, 0);

    // Reset asserted while sitting in MEMWRITE
    v.instr = I_SW; v.z = 0;
    v.name = "mwr.rst";  v.mr = 1; v.rst = 1;
    v.exp = ev(0,0,0,0,2'b10,2'b00,2'b10,3'b001,3'b000,0); apply(v);
    v.name = "mwr.F";    v.rst = 0; v.exp = xf(1, 3'b001); apply(v);
    v.name = "mwr.D";    v.exp = xd(3'b001); apply(v);
    v.name = "mwr.MA";   v.exp = ev(0,0,0,0,2'b00,2'b10,2'b01,3'b001,3'b000,0); apply(v);
    v.name = "mwr.MW";   v.mr = 0; v.exp = ev(0,1,1,0,2'b00,2'b00,2'b00,3'b001,3'b000,0); apply(v);
    v.name = "mwr.MWrst"; v.rst = 1;
    v.exp = ev(0,0,0,0,2'b10,2'b00,2'b10,3'b001,3'b000,0); apply(v);
    v.name = "mwr.after"; v.rst = 0; v.mr = 1; v.exp = xf(1, 3'b001); apply(v);
    v.name = "mwr.after.D"; v.exp = xd(3'b001); apply(v);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
